// File: rtl/pwm_pkg.sv
// Shared register map, PWM step count and register type for the PWM peripheral.
package pwm_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY      = 7'd4;

  // Steps per PWM period; the step counter runs 0..PWM_STEPS-1.
  localparam int PWM_STEPS = 255;

  typedef logic [7:0] reg8_t;

endpackage

// File: rtl/pwm_counter.sv
// PWM timebase: prescaler, 8-bit step counter and the period-wrap pulse.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] step,
  output logic       tick,
  output logic       period_start
);

  logic [7:0] presc;

  assign tick         = (presc == 8'(CLK_DIV - 1));
  assign period_start = tick && (step == 8'(PWM_STEPS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      step  <= '0;
    end else begin
      presc <= tick ? 8'd0 : presc + 8'd1;
      if (period_start)
        step <= '0;
      else if (tick)
        step <= step + 8'd1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral top: register file, duty source and registered output mux.
// Optional build macro PWM_SHADOW_EN latches duty only at each period start.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV  = 10,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       wr_err,
  output logic [7:0] out_lo,
  output logic [7:0] out_hi,
  output logic       pwm_period_start
);

  reg8_t       en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  reg8_t       duty_act;
  logic [7:0]  step;
  logic        period_start;
  logic        tick_unused;
  logic        pwm_q;
  logic        wr_ok;
  logic [15:0] en_out, en_pwm, out_q;

  pwm_counter #(.CLK_DIV(CLK_DIV)) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .step         (step),
    .tick         (tick_unused),
    .period_start (period_start)
  );

  // Full 7-bit compare: high address bits are never dropped.
  assign wr_ok = wr_valid && (wr_addr <= 7'(MAX_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_lo <= '0;
      en_out_hi <= '0;
      en_pwm_lo <= '0;
      en_pwm_hi <= '0;
      duty      <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= wr_valid && !wr_ok;
      if (wr_ok) begin
        case (wr_addr)
          ADDR_EN_OUT_LO: en_out_lo <= wr_data;
          ADDR_EN_OUT_HI: en_out_hi <= wr_data;
          ADDR_EN_PWM_LO: en_pwm_lo <= wr_data;
          ADDR_EN_PWM_HI: en_pwm_hi <= wr_data;
          ADDR_DUTY:      duty      <= wr_data;
          default: ;
        endcase
      end
    end
  end

`ifdef PWM_SHADOW_EN
  // A duty write in the period-start cycle is not yet visible here, so it
  // lands one period later.
  always_ff @(posedge clk) begin
    if (rst)
      duty_act <= '0;
    else if (period_start)
      duty_act <= duty;
  end
`else
  assign duty_act = duty;
`endif

  assign en_out = {en_out_hi, en_out_lo};
  assign en_pwm = {en_pwm_hi, en_pwm_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= 1'b0;
      out_q <= '0;
    end else begin
      pwm_q <= (duty_act == 8'hFF) ? 1'b1 : (step < duty_act);
      out_q <= en_out & (~en_pwm | {16{pwm_q}});
    end
  end

  assign out_lo           = out_q[7:0];
  assign out_hi           = out_q[15:8];
  assign pwm_period_start = period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral (CLK_DIV=10, 2550 clks/period).
module tb_pwm_peripheral;

  localparam int PERIOD_CLKS = 2550;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack, wr_err;
  logic [7:0] out_lo, out_hi;
  logic       pwm_period_start;

  int checks = 0;
  int errors = 0;

  pwm_peripheral #(.CLK_DIV(10), .MAX_ADDR(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_valid         (wr_valid),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ack           (wr_ack),
    .wr_err           (wr_err),
    .out_lo           (out_lo),
    .out_hi           (out_hi),
    .pwm_period_start (pwm_period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d, output logic ack, output logic err);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cyc();
    ack      = wr_ack;
    err      = wr_err;
    wr_valid = 1'b0;
  endtask

  // Returns in the cycle where pwm_period_start is high; n = cycles waited.
  task automatic wait_ps(input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      n++;
      if (pwm_period_start) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Counts cycles with bit0 high; bad counts cycles where bits 15:1 are not all 1.
  task automatic count_bit0(input int n, output int hi, output int bad);
    hi = 0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (out_lo[0]) hi++;
      if (out_hi !== 8'hFF || out_lo[7:1] !== 7'h7F) bad++;
    end
  endtask

  initial begin
    logic ack, err;
    int   n, hi, bad;

    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) cyc();
    check("rst_out_lo", 32'(out_lo), 32'h0);
    check("rst_out_hi", 32'(out_hi), 32'h0);
    check("rst_wr_ack", 32'(wr_ack), 32'h0);
    check("rst_wr_err", 32'(wr_err), 32'h0);
    check("rst_step",   32'(dut.u_cnt.step), 32'h0);
    rst = 1'b0;

    // Static outputs, back-to-back writes.
    wr(7'd2, 8'h00, ack, err);
    check("wr_en_pwm_lo_ack", 32'(ack), 32'h1);
    wr(7'd3, 8'h00, ack, err);
    check("wr_en_pwm_hi_ack", 32'(ack), 32'h1);
    wr(7'd0, 8'hA5, ack, err);
    check("wr0_ack", 32'(ack), 32'h1);
    check("wr0_err", 32'(err), 32'h0);
    wr(7'd1, 8'h3C, ack, err);
    check("wr1_ack", 32'(ack), 32'h1);
    cyc();
    check("static_out_lo", 32'(out_lo), 32'hA5);
    check("static_out_hi", 32'(out_hi), 32'h3C);
    check("ack_single_pulse", 32'(wr_ack), 32'h0);

    // 50% duty on bit0, all other bits static high.
    wr(7'd0, 8'hFF, ack, err);
    wr(7'd1, 8'hFF, ack, err);
    wr(7'd2, 8'h01, ack, err);
    wr(7'd4, 8'h80, ack, err);
    wait_ps("ps_first", n);
    wait_ps("ps_second", n);
    check("period_len", 32'(n), 32'(PERIOD_CLKS));
    count_bit0(PERIOD_CLKS, hi, bad);
    check("duty80_high", 32'(hi), 32'd1280);
    check("duty80_low", 32'(PERIOD_CLKS - hi), 32'd1270);
    check("duty80_others", 32'(bad), 32'd0);

    // Duty extremes over three full periods.
    wr(7'd4, 8'h00, ack, err);
    wait_ps("ps_d00_a", n);
    wait_ps("ps_d00_b", n);
    count_bit0(3 * PERIOD_CLKS, hi, bad);
    check("duty00_high", 32'(hi), 32'd0);
    check("duty00_others", 32'(bad), 32'd0);
    wr(7'd4, 8'hFF, ack, err);
    wait_ps("ps_dff_a", n);
    wait_ps("ps_dff_b", n);
    count_bit0(3 * PERIOD_CLKS, hi, bad);
    check("dutyff_high", 32'(hi), 32'(3 * PERIOD_CLKS));
    check("dutyff_others", 32'(bad), 32'd0);

    // Invalid addresses, including ones whose low bits alias valid registers.
    wr(7'd5, 8'h00, ack, err);
    check("addr05_err", 32'(err), 32'h1);
    check("addr05_ack", 32'(ack), 32'h0);
    wr(7'h7F, 8'h00, ack, err);
    check("addr7f_err", 32'(err), 32'h1);
    check("addr7f_ack", 32'(ack), 32'h0);
    wr(7'h08, 8'h00, ack, err);
    check("addr08_err", 32'(err), 32'h1);
    wr(7'h7C, 8'h00, ack, err);
    check("addr7c_err", 32'(err), 32'h1);
    cyc();
    check("err_single_pulse", 32'(wr_err), 32'h0);
    count_bit0(PERIOD_CLKS, hi, bad);
    check("bad_wr_duty_kept", 32'(hi), 32'(PERIOD_CLKS));
    check("bad_wr_en_kept", 32'(bad), 32'd0);

    // Mid-period duty change: 0x80 -> 0x40 at step ~100.
    wr(7'd4, 8'h80, ack, err);
    wait_ps("ps_sh_a", n);
    wait_ps("ps_sh_b", n);
    repeat (1000) cyc();
    check("mid_bit0_before", 32'(out_lo[0]), 32'h1);
    wr(7'd4, 8'h40, ack, err);
    repeat (2) cyc();
`ifdef PWM_SHADOW_EN
    check("mid_bit0_after", 32'(out_lo[0]), 32'h1);
`else
    check("mid_bit0_after", 32'(out_lo[0]), 32'h0);
`endif
    wait_ps("ps_sh_c", n);
    count_bit0(PERIOD_CLKS, hi, bad);
    check("duty40_high", 32'(hi), 32'd640);

    // Reset mid-period with a write in flight.
    repeat (300) cyc();
    check("pre_rst_out_lo", 32'(out_lo), 32'hFF);
    rst = 1'b1;
    wr_valid = 1'b1; wr_addr = 7'd0; wr_data = 8'hFF;
    cyc();
    wr_valid = 1'b0;
    check("midrst_out_lo", 32'(out_lo), 32'h0);
    check("midrst_out_hi", 32'(out_hi), 32'h0);
    check("midrst_wr_ack", 32'(wr_ack), 32'h0);
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("post_rst_out_lo", 32'(out_lo), 32'h0);
    check("post_rst_out_hi", 32'(out_hi), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
